game_sequencer: RTL
===================

Name: game_sequencer

Overview:
- Top-level round controller for the guitar game.
- Sequences IDLE → countdown → play → game-over.
- Gates the music player and note shifter enables.
- Judges each judge-row note against player buttons once per note-shift tick, and keeps score, combo/multiplier and lives.
- Replaces the ad-hoc score logic; its score feeds the 7-segment display path and its enables feed music/shifter.

Parameters:
- TICKS_PER_STEP, 100_000_000: clk cycles per countdown step (1 s at 100 MHz).
- COUNT_STEPS, 3: countdown length in steps.
- MAX_LIVES, 5: misses allowed before game over.
- COMBO_PER_MULT, 8: consecutive hits per multiplier increment.
- MAX_MULT, 4: multiplier ceiling.
- SCORE_MAX, 9999: score saturation value (4-digit display).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  start button, level; internally rising-edge detected.
- note_tick  in  1  one-cycle pulse from shifter: judge window closes.
- hit_lane  in  4  lane mask of note currently in judge row; 0 = empty row.
- buttons  in  4  debounced lane buttons, active-high.
- song_done  in  1  one-cycle pulse: music reached end of song.
- music_en  out  1  run enable to music player.
- shifter_en  out  1  run enable to note shifter.
- score  out  14  saturating score, 0..SCORE_MAX.
- combo  out  8  consecutive hits, saturates at 255.
- mult  out  3  current multiplier, 1..MAX_MULT.
- lives  out  3  remaining lives.
- countdown  out  2  remaining countdown steps; 0 outside COUNTDOWN.
- state_o  out  3  encoded FSM state for display/debug.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (reset==0 at clk edge):
  - State IDLE; music_en = shifter_en = 0.
  - score = 0, combo = 0, mult = 1, lives = MAX_LIVES, countdown = 0, game_over = 0.
  - Timers cleared, match flag cleared, start-edge register cleared.
  - Reset mid-game aborts immediately; no partial judge.
- start_rise = start & ~start_q, registered one cycle.
- States and encoding:
  - IDLE = 0: enables low.
    - On start_rise: clear score/combo/lives to initial values.
    - Set countdown = COUNT_STEPS, go COUNTDOWN.
  - COUNTDOWN = 1: cycle timer counts 0..TICKS_PER_STEP-1.
    - At wrap, countdown decrements.
    - When it would reach 0, go PLAY next cycle.
    - Total COUNT_STEPS*TICKS_PER_STEP cycles. start_rise ignored.
  - PLAY = 2: music_en = shifter_en = 1, registered; high from the first PLAY cycle.
  - PAUSE = 3: exists only with the optional feature.
  - OVER = 4: enables low, game_over = 1, score held. start_rise → IDLE.
- Judging in PLAY:
  - match flag sets on any cycle where hit_lane != 0 and buttons == hit_lane (exact mask).
  - On a note_tick cycle, the tick cycle itself counts: hit = match | (buttons == hit_lane).
  - At note_tick with hit_lane == 0: no change; match cleared.
  - At note_tick with hit_lane != 0 and hit:
    - score += mult, saturating at SCORE_MAX.
    - combo += 1, saturating at 255.
  - At note_tick with hit_lane != 0 and no hit: combo = 0, lives -= 1.
  - match cleared every note_tick.
  - mult = min(MAX_MULT, 1 + combo/COMBO_PER_MULT), combinational from registered combo. The judge uses mult before the update.
- Game-over transitions:
  - lives reaching 0 → OVER next cycle.
  - song_done in PLAY → OVER next cycle.
  - song_done coincident with note_tick: the note is judged first, then OVER.
  - note_tick/song_done outside PLAY are ignored.
- Score/lives never wrap; lives never decrements below 0.

Optional Feature:
- Macro: GAME_SEQUENCER_PAUSE_EN.
- When defined:
  - start_rise in PLAY → PAUSE: enables drop next cycle; note_tick and song_done ignored; match flag held.
  - start_rise in PAUSE → PLAY, with all counters preserved.
  - state_o = 3 in PAUSE.
- When undefined:
  - start_rise in PLAY is ignored; the PAUSE state does not exist.

Test Plan:
- Reset then start pulse with TICKS_PER_STEP=4, COUNT_STEPS=3 → countdown 3,2,1 at 4-cycle spacing; music_en = 1 exactly 12 cycles after COUNTDOWN entry; lives = 5, score = 0.
- PLAY, hit_lane=4'b0101, buttons=0101 for 1 cycle mid-window, note_tick → score = 1, combo = 1. Repeat 8 hits → combo = 8, mult = 2; 9th hit → score = 10.
- hit_lane=4'b0010, buttons=0011 whole window → miss: combo = 0, lives = 4, score unchanged. hit_lane=0 tick → no change.
- 5 consecutive misses → lives = 0, state_o = 4, game_over = 1, enables 0. start pulse → IDLE; next start restores lives = 5.
- song_done with note_tick and a matched note on the same cycle → score incremented, then OVER. Score preloaded at 9998 with mult=4 hit → score = 9999.
- With GAME_SEQUENCER_PAUSE_EN: start in PLAY → state_o = 3, enables 0, note_tick ignored; start again → PLAY with score/combo unchanged. Without the macro: start in PLAY has no effect. reset low mid-PLAY → all outputs at reset values next cycle.

Source files
------------

// File: rtl/game_sequencer.sv
// Round controller for the guitar game: countdown, play, judging, score/lives.
// Optional pause on start button in PLAY when GAME_SEQUENCER_PAUSE_EN is defined.
module game_sequencer #(
    parameter int TICKS_PER_STEP = 100_000_000,
    parameter int COUNT_STEPS    = 3,
    parameter int MAX_LIVES      = 5,
    parameter int COMBO_PER_MULT = 8,
    parameter int MAX_MULT       = 4,
    parameter int SCORE_MAX      = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        note_tick,
    input  logic [3:0]  hit_lane,
    input  logic [3:0]  buttons,
    input  logic        song_done,
    output logic        music_en,
    output logic        shifter_en,
    output logic [13:0] score,
    output logic [7:0]  combo,
    output logic [2:0]  mult,
    output logic [2:0]  lives,
    output logic [1:0]  countdown,
    output logic [2:0]  state_o,
    output logic        game_over
);

    localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t        state;
    state_t        next;
    logic          start_q;
    logic          rise_q;
    logic [TW-1:0] timer;
    logic          match;

    logic          step_wrap;
    logic          judge;
    logic          lane_eq;
    logic          hit;
    logic          miss;
    logic [8:0]    m_raw;
    logic [14:0]   sum;
    logic [13:0]   sum_sat;

    assign step_wrap = (timer == TW'(TICKS_PER_STEP - 1));
    assign judge     = (state == S_PLAY) && note_tick && (hit_lane != 4'd0);
    assign lane_eq   = (hit_lane != 4'd0) && (buttons == hit_lane);
    assign hit       = match | lane_eq;
    assign miss      = judge && !hit;

    // Multiplier follows the registered combo, so a judge uses the old value.
    assign m_raw = 9'(combo / COMBO_PER_MULT) + 9'd1;
    assign mult  = (m_raw > 9'(MAX_MULT)) ? 3'(MAX_MULT) : m_raw[2:0];

    assign sum     = {1'b0, score} + {12'd0, mult};
    assign sum_sat = (sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : sum[13:0];

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:  if (rise_q) next = S_COUNT;
            S_COUNT: if (step_wrap && countdown <= 2'd1) next = S_PLAY;
            S_PLAY: begin
                if (song_done || lives == 3'd0 || (miss && lives <= 3'd1))
                    next = S_OVER;
`ifdef GAME_SEQUENCER_PAUSE_EN
                else if (rise_q)
                    next = S_PAUSE;
`endif
            end
`ifdef GAME_SEQUENCER_PAUSE_EN
            S_PAUSE: if (rise_q) next = S_PLAY;
`endif
            S_OVER:  if (rise_q) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_comb begin
        music_en   = (state == S_PLAY);
        shifter_en = (state == S_PLAY);
        game_over  = (state == S_OVER);
        state_o    = state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            start_q   <= 1'b0;
            rise_q    <= 1'b0;
            timer     <= '0;
            countdown <= 2'd0;
            score     <= 14'd0;
            combo     <= 8'd0;
            lives     <= 3'(MAX_LIVES);
            match     <= 1'b0;
        end else begin
            start_q <= start;
            rise_q  <= start & ~start_q;
            unique case (state)
                S_IDLE: begin
                    if (rise_q) begin
                        score     <= 14'd0;
                        combo     <= 8'd0;
                        lives     <= 3'(MAX_LIVES);
                        countdown <= 2'(COUNT_STEPS);
                        timer     <= '0;
                        match     <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (step_wrap) begin
                        timer     <= '0;
                        countdown <= countdown - 2'd1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_PLAY: begin
                    if (note_tick) begin
                        match <= 1'b0;
                        if (judge && hit) begin
                            score <= sum_sat;
                            if (combo != 8'hFF) combo <= combo + 8'd1;
                        end else if (miss) begin
                            combo <= 8'd0;
                            if (lives != 3'd0) lives <= lives - 3'd1;
                        end
                    end else if (lane_eq) begin
                        match <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
